// File: rtl/ita_job_dispatcher.sv
// ita_job_dispatcher
//   Writes job descriptors into the ITA HWPE register map through its
//   peripheral slave port. Each job is one acquire read, then N_REGS
//   job-register writes, then a trigger write. In-flight jobs are limited
//   to N_CONTEXT and retired on the accelerator's done event.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_i                synchronous soft clear (FSM, counters)
//   desc_*                 descriptor word stream (valid/ready/data)
//   periph_*               HWPE peripheral port (req/gnt, add, wen, be,
//                          data, id, r_valid, r_data)
//   evt_done_i             one-cycle job-done event from the accelerator
//   busy_o                 FSM not idle or any job in flight
//   inflight_o             jobs triggered and not yet done
//   job_done_o             one-cycle pulse per retired job
//
// Optional build macro ITA_DISPATCH_PERF_EN adds the saturating
// performance counters perf_jobs_o, perf_retry_o and perf_stall_o.

module ita_job_dispatcher #(
  parameter int unsigned N_REGS     = 15,
  parameter int unsigned N_CONTEXT  = 2,
  parameter int unsigned ID_WIDTH   = 2,
  parameter logic [31:0] JOB_BASE   = 32'h40,
  parameter int unsigned RETRY_WAIT = 8,
  localparam int unsigned CNT_W     = $clog2(N_CONTEXT + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                desc_valid_i,
  output logic                desc_ready_o,
  input  logic [31:0]         desc_data_i,
  output logic                periph_req_o,
  input  logic                periph_gnt_i,
  output logic [31:0]         periph_add_o,
  output logic                periph_wen_o,
  output logic [3:0]          periph_be_o,
  output logic [31:0]         periph_data_o,
  output logic [ID_WIDTH-1:0] periph_id_o,
  input  logic                periph_r_valid_i,
  input  logic [31:0]         periph_r_data_i,
  input  logic                evt_done_i,
  output logic                busy_o,
  output logic [CNT_W-1:0]    inflight_o,
`ifdef ITA_DISPATCH_PERF_EN
  output logic [31:0]         perf_jobs_o,
  output logic [31:0]         perf_retry_o,
  output logic [31:0]         perf_stall_o,
`endif
  output logic                job_done_o
);

  localparam int unsigned IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int unsigned RW_W  = (RETRY_WAIT > 1) ? $clog2(RETRY_WAIT) : 1;

  localparam logic [31:0] ACQ_ADDR  = 32'h04;
  localparam logic [31:0] TRIG_ADDR = 32'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACQ,
    S_ACQ_WAIT,
    S_RETRY,
    S_WRITE,
    S_TRIG
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [RW_W-1:0]  retry_q, retry_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             job_done_q, job_done_d;

  logic             trig_fire;
  logic             acq_refused;
  logic             done_ok;

  // Only bit 31 of the acquire response carries information.
  logic             unused_r_data;
  assign unused_r_data = ^periph_r_data_i[30:0];

`ifdef ITA_DISPATCH_PERF_EN
  logic [31:0] perf_jobs_q, perf_jobs_d;
  logic [31:0] perf_retry_q, perf_retry_d;
  logic [31:0] perf_stall_q, perf_stall_d;
`endif

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    retry_d       = retry_q;
    inflight_d    = inflight_q;
    job_done_d    = 1'b0;
    trig_fire     = 1'b0;
    acq_refused   = 1'b0;
    periph_req_o  = 1'b0;
    periph_wen_o  = 1'b0;
    periph_add_o  = 32'h0;
    periph_data_o = 32'h0;
    desc_ready_o  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (desc_valid_i && (inflight_q < CNT_W'(N_CONTEXT))) begin
          state_d = S_ACQ;
        end
      end
      S_ACQ: begin
        periph_req_o = 1'b1;
        periph_wen_o = 1'b1;
        periph_add_o = ACQ_ADDR;
        if (periph_gnt_i) begin
          state_d = S_ACQ_WAIT;
        end
      end
      S_ACQ_WAIT: begin
        if (periph_r_valid_i) begin
          // Bit 31 set means the accelerator has no free job context.
          if (periph_r_data_i[31]) begin
            state_d     = S_RETRY;
            retry_d     = '0;
            acq_refused = 1'b1;
          end else begin
            state_d = S_WRITE;
            idx_d   = '0;
          end
        end
      end
      S_RETRY: begin
        if (retry_q == RW_W'(RETRY_WAIT - 1)) begin
          state_d = S_ACQ;
          retry_d = '0;
        end else begin
          retry_d = retry_q + 1'b1;
        end
      end
      S_WRITE: begin
        // The write is a pass-through of the descriptor stream: a word is
        // consumed exactly when the bus grants it.
        periph_req_o  = desc_valid_i;
        periph_add_o  = JOB_BASE + {{(32 - IDX_W - 2){1'b0}}, idx_q, 2'b00};
        periph_data_o = desc_data_i;
        desc_ready_o  = periph_gnt_i & desc_valid_i;
        if (desc_valid_i && periph_gnt_i) begin
          if (idx_q == IDX_W'(N_REGS - 1)) begin
            state_d = S_TRIG;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_TRIG: begin
        periph_req_o = 1'b1;
        periph_add_o = TRIG_ADDR;
        if (periph_gnt_i) begin
          trig_fire = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A done event with nothing in flight is spurious and dropped.
    done_ok    = evt_done_i && (inflight_q != '0);
    job_done_d = done_ok;
    case ({trig_fire, done_ok})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase

`ifdef ITA_DISPATCH_PERF_EN
    perf_jobs_d  = perf_jobs_q;
    perf_retry_d = perf_retry_q;
    perf_stall_d = perf_stall_q;
    if (trig_fire && (perf_jobs_q != 32'hFFFF_FFFF)) begin
      perf_jobs_d = perf_jobs_q + 32'd1;
    end
    if (acq_refused && (perf_retry_q != 32'hFFFF_FFFF)) begin
      perf_retry_d = perf_retry_q + 32'd1;
    end
    if ((state_q == S_WRITE) && !desc_valid_i && (perf_stall_q != 32'hFFFF_FFFF)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
`endif

    // Soft clear wins over everything; the bus side is silenced in the same
    // cycle so no word is consumed that the FSM then forgets.
    if (clear_i) begin
      state_d       = S_IDLE;
      idx_d         = '0;
      retry_d       = '0;
      inflight_d    = '0;
      job_done_d    = 1'b0;
      periph_req_o  = 1'b0;
      periph_wen_o  = 1'b0;
      periph_add_o  = 32'h0;
      periph_data_o = 32'h0;
      desc_ready_o  = 1'b0;
`ifdef ITA_DISPATCH_PERF_EN
      perf_jobs_d  = '0;
      perf_retry_d = '0;
      perf_stall_d = '0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      retry_q    <= '0;
      inflight_q <= '0;
      job_done_q <= 1'b0;
`ifdef ITA_DISPATCH_PERF_EN
      perf_jobs_q  <= '0;
      perf_retry_q <= '0;
      perf_stall_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      inflight_q <= inflight_d;
      job_done_q <= job_done_d;
`ifdef ITA_DISPATCH_PERF_EN
      perf_jobs_q  <= perf_jobs_d;
      perf_retry_q <= perf_retry_d;
      perf_stall_q <= perf_stall_d;
`endif
    end
  end

  assign periph_be_o = 4'hF;
  assign periph_id_o = '0;
  assign busy_o      = (state_q != S_IDLE) || (inflight_q != '0);
  assign inflight_o  = inflight_q;
  assign job_done_o  = job_done_q;

`ifdef ITA_DISPATCH_PERF_EN
  assign perf_jobs_o  = perf_jobs_q;
  assign perf_retry_o = perf_retry_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_ita_job_dispatcher.sv
// Directed testbench for ita_job_dispatcher. A bus/stream driver process
// grants requests, answers acquire reads and feeds descriptor words; the main
// sequence issues jobs and checks the logged bus transactions and status.

module tb_ita_job_dispatcher;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic        desc_valid_i;
  logic        desc_ready_o;
  logic [31:0] desc_data_i;
  logic        periph_req_o;
  logic        periph_gnt_i;
  logic [31:0] periph_add_o;
  logic        periph_wen_o;
  logic [3:0]  periph_be_o;
  logic [31:0] periph_data_o;
  logic [1:0]  periph_id_o;
  logic        periph_r_valid_i;
  logic [31:0] periph_r_data_i;
  logic        evt_done_i;
  logic        busy_o;
  logic [1:0]  inflight_o;
  logic        job_done_o;
`ifdef ITA_DISPATCH_PERF_EN
  logic [31:0] perf_jobs_o, perf_retry_o, perf_stall_o;
`endif

  always #5 clk_i = ~clk_i;

  ita_job_dispatcher dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .clear_i          (clear_i),
    .desc_valid_i     (desc_valid_i),
    .desc_ready_o     (desc_ready_o),
    .desc_data_i      (desc_data_i),
    .periph_req_o     (periph_req_o),
    .periph_gnt_i     (periph_gnt_i),
    .periph_add_o     (periph_add_o),
    .periph_wen_o     (periph_wen_o),
    .periph_be_o      (periph_be_o),
    .periph_data_o    (periph_data_o),
    .periph_id_o      (periph_id_o),
    .periph_r_valid_i (periph_r_valid_i),
    .periph_r_data_i  (periph_r_data_i),
    .evt_done_i       (evt_done_i),
    .busy_o           (busy_o),
    .inflight_o       (inflight_o),
`ifdef ITA_DISPATCH_PERF_EN
    .perf_jobs_o      (perf_jobs_o),
    .perf_retry_o     (perf_retry_o),
    .perf_stall_o     (perf_stall_o),
`endif
    .job_done_o       (job_done_o)
  );

  // ---------------- shared state (each variable has one writer) ----------
  // written by main
  logic [31:0] desc_mem [0:255];
  int          desc_avail = 0;
  logic [31:0] acq_resp [0:15];
  int          acq_wr = 0;
  int          flush_cnt = 0;
  bit          gnt_rand = 1'b0;
  bit          gap_en = 1'b0;
  // written by driver
  int          desc_rd = 0;
  int          acq_rd = 0;
  int          flush_seen = 0;
  int          cyc = 0;
  int          log_n = 0;
  logic [31:0] log_add [0:511];
  logic [31:0] log_data [0:511];
  logic        log_wen [0:511];
  int          log_cyc [0:511];
  int          stall_cnt = 0;
  int          done_cnt = 0;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input int j, input int i);
    return 32'hC0DE_0000 | (32'(j) << 8) | 32'(i);
  endfunction

  // ---------------- driver: bus slave, acquire responder, desc source -----
  initial begin : driver
    bit pending_resp = 1'b0;
    bit write_armed = 1'b0;
    bit in_write = 1'b0;
    int wr_words = 0;
    periph_gnt_i = 1'b0;
    periph_r_valid_i = 1'b0;
    periph_r_data_i = 32'h0;
    desc_valid_i = 1'b0;
    desc_data_i = 32'h0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (flush_cnt != flush_seen) begin
        desc_rd = desc_avail;
        flush_seen = flush_cnt;
      end
      if (!rst_ni) begin
        pending_resp = 1'b0;
        write_armed = 1'b0;
        in_write = 1'b0;
      end
      if (write_armed) begin
        in_write = 1'b1;
        wr_words = 0;
        write_armed = 1'b0;
      end
      if (pending_resp) begin
        periph_r_valid_i = 1'b1;
        if (acq_rd < acq_wr) begin
          periph_r_data_i = acq_resp[acq_rd];
          acq_rd++;
        end else begin
          periph_r_data_i = 32'h0000_0000;
        end
        if (!periph_r_data_i[31]) write_armed = 1'b1;
        pending_resp = 1'b0;
      end else begin
        periph_r_valid_i = 1'b0;
        periph_r_data_i = 32'h0;
      end
      periph_gnt_i = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      desc_valid_i = (desc_rd < desc_avail) && (!gap_en || ($urandom_range(0, 3) != 0));
      desc_data_i = desc_valid_i ? desc_mem[desc_rd] : 32'h0;
      #1;
      if (in_write && !desc_valid_i) stall_cnt++;
      if (job_done_o) done_cnt++;
      if (periph_req_o && periph_gnt_i) begin
        log_add[log_n] = periph_add_o;
        log_data[log_n] = periph_data_o;
        log_wen[log_n] = periph_wen_o;
        log_cyc[log_n] = cyc;
        log_n++;
        $display("[TB] txn cyc=%0d %s add=%08h data=%08h", cyc,
                 periph_wen_o ? "RD" : "WR", periph_add_o, periph_data_o);
        if (periph_wen_o) pending_resp = 1'b1;
        else if (in_write && (periph_add_o != 32'h0)) begin
          wr_words++;
          if (wr_words == 15) in_write = 1'b0;
        end
      end
      if (desc_valid_i && desc_ready_o) desc_rd++;
    end
  end

  // ---------------- helpers ------------------------------------------------
  task automatic push_job(input int j);
    for (int i = 0; i < 15; i++) desc_mem[desc_avail + i] = word(j, i);
    desc_avail = desc_avail + 15;
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    for (int k = 0; k < budget && log_n < n; k++) begin
      @(negedge clk_i); #2;
    end
    chk(tag, 32'(log_n >= n), 32'd1);
  endtask

  task automatic check_job(input int b, input int j);
    chk("acq_add", log_add[b], 32'h04);
    chk("acq_wen", 32'(log_wen[b]), 32'd1);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("wr%0d_add", i), log_add[b + 1 + i], 32'h40 + 32'(4 * i));
      chk($sformatf("wr%0d_wen", i), 32'(log_wen[b + 1 + i]), 32'd0);
      chk($sformatf("wr%0d_data", i), log_data[b + 1 + i], word(j, i));
    end
    chk("trig_add", log_add[b + 16], 32'h00);
    chk("trig_wen", 32'(log_wen[b + 16]), 32'd0);
    chk("trig_data", log_data[b + 16], 32'h0);
  endtask

  // One-cycle done event; checks pulse and count the cycle after.
  task automatic pulse_evt(input logic exp_done, input logic [1:0] exp_inflight);
    @(negedge clk_i); evt_done_i = 1'b1;
    @(negedge clk_i); evt_done_i = 1'b0;
    #2;
    chk("evt_job_done", 32'(job_done_o), 32'(exp_done));
    chk("evt_inflight", 32'(inflight_o), 32'(exp_inflight));
    @(negedge clk_i); #2;
    chk("evt_done_drop", 32'(job_done_o), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main directed sequence ---------------------------------
  initial begin : main
    int base;
    int d0;
    bit found;
    rst_ni = 1'b0;
    clear_i = 1'b0;
    evt_done_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #2;
    chk("rst_req", 32'(periph_req_o), 32'd0);
    chk("rst_ready", 32'(desc_ready_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_inflight", 32'(inflight_o), 32'd0);
    chk("rst_job_done", 32'(job_done_o), 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;

    // Single job, zero stall.
    base = log_n;
    push_job(0);
    wait_log(base + 17, 200, "t1_txns");
    check_job(base, 0);
    repeat (3) @(negedge clk_i);
    #2;
    chk("t1_inflight", 32'(inflight_o), 32'd1);
    chk("t1_busy", 32'(busy_o), 32'd1);
    repeat (20) @(negedge clk_i);
    pulse_evt(1'b1, 2'd0);
    chk("t1_busy_end", 32'(busy_o), 32'd0);

    // Three back-to-back jobs against a two-context limit.
    base = log_n;
    push_job(1); push_job(2); push_job(3);
    wait_log(base + 34, 400, "t2_two_jobs");
    repeat (10) @(negedge clk_i);
    #2;
    chk("t2_third_held", 32'(log_n), 32'(base + 34));
    chk("t2_no_req", 32'(periph_req_o), 32'd0);
    chk("t2_inflight_full", 32'(inflight_o), 32'd2);
    check_job(base, 1);
    check_job(base + 17, 2);
    @(negedge clk_i); evt_done_i = 1'b1;
    @(negedge clk_i); evt_done_i = 1'b0;
    chk("t2_done_pulse", 32'(job_done_o), 32'd1);
    @(negedge clk_i); #2;
    chk("t2_acq_req", 32'(periph_req_o), 32'd1);
    chk("t2_acq_add", periph_add_o, 32'h04);
    wait_log(base + 51, 200, "t2_third_job");
    check_job(base + 34, 3);
    repeat (2) @(negedge clk_i);
    #2;
    chk("t2_inflight_end", 32'(inflight_o), 32'd2);
    pulse_evt(1'b1, 2'd1);
    pulse_evt(1'b1, 2'd0);

    // Refused acquires then success.
    base = log_n;
    acq_resp[acq_wr] = 32'hFFFF_FFFF; acq_wr++;
    acq_resp[acq_wr] = 32'hFFFF_FFFF; acq_wr++;
    acq_resp[acq_wr] = 32'h0000_0001; acq_wr++;
    push_job(4);
    wait_log(base + 19, 400, "t3_txns");
    chk("t3_acq0_add", log_add[base], 32'h04);
    chk("t3_acq1_add", log_add[base + 1], 32'h04);
    chk("t3_acq1_wen", 32'(log_wen[base + 1]), 32'd1);
    chk("t3_gap01", 32'((log_cyc[base + 1] - log_cyc[base]) >= 9), 32'd1);
    chk("t3_gap12", 32'((log_cyc[base + 2] - log_cyc[base + 1]) >= 9), 32'd1);
    check_job(base + 2, 4);
    repeat (2) @(negedge clk_i);
`ifdef ITA_DISPATCH_PERF_EN
    #2;
    chk("t3_perf_retry", perf_retry_o, 32'd2);
    chk("t3_perf_jobs", perf_jobs_o, 32'd5);
`endif
    pulse_evt(1'b1, 2'd0);

    // Random grant backpressure and descriptor gaps.
    base = log_n;
    gnt_rand = 1'b1;
    gap_en = 1'b1;
    push_job(5);
    wait_log(base + 17, 2000, "t4_txns");
    gnt_rand = 1'b0;
    gap_en = 1'b0;
    repeat (5) @(negedge clk_i);
    #2;
    chk("t4_txn_count", 32'(log_n), 32'(base + 17));
    chk("t4_all_consumed", 32'(desc_rd), 32'(desc_avail));
    check_job(base, 5);
    chk("t4_inflight", 32'(inflight_o), 32'd1);
`ifdef ITA_DISPATCH_PERF_EN
    chk("t4_perf_stall", perf_stall_o, 32'(stall_cnt));
`endif

    // Done event coincident with the trigger grant, inflight=1.
    base = log_n;
    push_job(6);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk_i); #2;
      if (periph_req_o && !periph_wen_o && (periph_add_o == 32'h0)) found = 1'b1;
    end
    chk("t5_trig_seen", 32'(found), 32'd1);
    d0 = done_cnt;
    evt_done_i = 1'b1;
    @(negedge clk_i); evt_done_i = 1'b0;
    #2;
    chk("t5_done_pulse", 32'(job_done_o), 32'd1);
    chk("t5_inflight", 32'(inflight_o), 32'd1);
    @(negedge clk_i); #2;
    chk("t5_inflight_hold", 32'(inflight_o), 32'd1);
    chk("t5_one_pulse", 32'(done_cnt - d0), 32'd1);
    check_job(base, 6);
    pulse_evt(1'b1, 2'd0);
    // Done event with nothing in flight.
    pulse_evt(1'b0, 2'd0);

    // Async reset in the middle of the register writes.
    base = log_n;
    push_job(7);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk_i); #2;
      if (log_n >= base + 8) found = 1'b1;
    end
    chk("t6_reached_idx7", 32'(found), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b0;
    flush_cnt++;
    #2;
    chk("t6_req", 32'(periph_req_o), 32'd0);
    chk("t6_ready", 32'(desc_ready_o), 32'd0);
    chk("t6_busy", 32'(busy_o), 32'd0);
    chk("t6_add", periph_add_o, 32'h0);
    chk("t6_data", periph_data_o, 32'h0);
    chk("t6_wen", 32'(periph_wen_o), 32'd0);
    chk("t6_inflight", 32'(inflight_o), 32'd0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);
    #2;
    chk("t6_quiet", 32'(log_n), 32'(base + 8));
    base = log_n;
    push_job(8);
    wait_log(base + 17, 200, "t6_restart");
    check_job(base, 8);
    repeat (2) @(negedge clk_i);
    #2;
    chk("t6_inflight_after", 32'(inflight_o), 32'd1);
`ifdef ITA_DISPATCH_PERF_EN
    chk("t6_perf_jobs", perf_jobs_o, 32'd1);
`endif

    // Soft clear drops the in-flight count.
    @(negedge clk_i); clear_i = 1'b1;
    @(negedge clk_i); clear_i = 1'b0;
    #2;
    chk("clr_inflight", 32'(inflight_o), 32'd0);
    chk("clr_busy", 32'(busy_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
